// File: rtl/datapath.sv
// Accumulator datapath for the small 4-bit-PC microprocessor.
// It holds ACC, an 8-entry register file, a 16-word data memory, an ALU and a
// shifter. The control unit supplies every enable and select on each cycle,
// so this block has no sequencing logic of its own.
// Every store (RF, MEM, output port) captures the ACC value from before the
// edge, while ACC itself takes the mux value. A read-modify-write in a single
// cycle therefore always sees consistent, pre-edge operands.
module datapath #(
  parameter int WIDTH     = 8,
  parameter int RF_DEPTH  = 8,
  parameter int MEM_DEPTH = 16
) (
  input  logic             clk_dp,
  input  logic             rst_dp,
  input  logic [1:0]       muxsel_dp,
  input  logic [WIDTH-1:0] imm_dp,
  input  logic [WIDTH-1:0] input_dp,
  input  logic             accwr_dp,
  input  logic [2:0]       rfaddr_dp,
  input  logic [3:0]       mmadr_dp,
  input  logic             mmwr_dp,
  input  logic             rfwr_dp,
  input  logic [2:0]       alusel_dp,
  input  logic [1:0]       shiftsel_dp,
  input  logic             outen_dp,
  output logic             zero_dp,
  output logic             positive_dp,
  output logic [WIDTH-1:0] output_dp
);

  // ALU operation encodings
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_NOT  = 3'b101;
  localparam logic [2:0] ALU_INC  = 3'b110;
  localparam logic [2:0] ALU_DEC  = 3'b111;

  // Shifter encodings
  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_SHR  = 2'b10;
  localparam logic [1:0] SH_ROR  = 2'b11;

  // ACC source encodings
  localparam logic [1:0] MUX_SHIFT = 2'b00;
  localparam logic [1:0] MUX_RF    = 2'b01;
  localparam logic [1:0] MUX_IN    = 2'b10;
  localparam logic [1:0] MUX_MEM   = 2'b11;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rf_q  [RF_DEPTH];
  logic [WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [WIDTH-1:0] rf_rd;
  logic [WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sh_res;

  // The immediate bus belongs to the control-unit interface, but this block
  // does not consume it.
  logic unused_imm;
  assign unused_imm = ^imm_dp;

  // Combinational read ports
  assign rf_rd  = rf_q[rfaddr_dp];
  assign mem_rd = mem_q[mmadr_dp];

  // ALU: ACC is always operand A and results wrap modulo 2^WIDTH
  always_comb begin
    alu_res = acc_q;
    unique case (alusel_dp)
      ALU_PASS: alu_res = acc_q;
      ALU_ADD:  alu_res = acc_q + rf_rd;
      ALU_SUB:  alu_res = acc_q - rf_rd;
      ALU_AND:  alu_res = acc_q & rf_rd;
      ALU_OR:   alu_res = acc_q | rf_rd;
      ALU_NOT:  alu_res = ~acc_q;
      ALU_INC:  alu_res = acc_q + WIDTH'(1);
      ALU_DEC:  alu_res = acc_q - WIDTH'(1);
      default:  alu_res = acc_q;
    endcase
  end

  // Shifter applied to the ALU result
  always_comb begin
    sh_res = alu_res;
    unique case (shiftsel_dp)
      SH_PASS: sh_res = alu_res;
      SH_SHL:  sh_res = {alu_res[WIDTH-2:0], 1'b0};
      SH_SHR:  sh_res = {1'b0, alu_res[WIDTH-1:1]};
      SH_ROR:  sh_res = {alu_res[0], alu_res[WIDTH-1:1]};
      default: sh_res = alu_res;
    endcase
  end

  // ACC input mux
  always_comb begin
    acc_d = sh_res;
    unique case (muxsel_dp)
      MUX_SHIFT: acc_d = sh_res;
      MUX_RF:    acc_d = rf_rd;
      MUX_IN:    acc_d = input_dp;
      MUX_MEM:   acc_d = mem_rd;
      default:   acc_d = sh_res;
    endcase
  end

  // ACC and output port registers; reset discards any pending write
  always_ff @(posedge clk_dp or posedge rst_dp) begin
    if (rst_dp) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      if (accwr_dp) acc_q <= acc_d;
      if (outen_dp) out_q <= acc_q;
    end
  end

  // Register file: written with the pre-edge ACC
  always_ff @(posedge clk_dp or posedge rst_dp) begin
    if (rst_dp) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rfwr_dp) begin
      rf_q[rfaddr_dp] <= acc_q;
    end
  end

  // Data memory: written with the pre-edge ACC
  always_ff @(posedge clk_dp or posedge rst_dp) begin
    if (rst_dp) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mmwr_dp) begin
      mem_q[mmadr_dp] <= acc_q;
    end
  end

  // Status flags follow the current ACC
  assign zero_dp     = (acc_q == '0);
  assign positive_dp = !acc_q[WIDTH-1] && (acc_q != '0);
  assign output_dp   = out_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the accumulator datapath. ACC is seen through the flags
// and through the output port: each check first copies ACC to output_dp.
// Expected {output_dp, zero, positive} tuples go into a queue, and a monitor
// pops and compares one tuple on every falling edge while the queue holds any.
module tb_datapath;

  localparam int W = 10;

  logic       clk_dp = 1'b0;
  logic       rst_dp = 1'b1;
  logic [1:0] muxsel_dp = '0;
  logic [7:0] imm_dp = '0;
  logic [7:0] input_dp = '0;
  logic       accwr_dp = 1'b0;
  logic [2:0] rfaddr_dp = '0;
  logic [3:0] mmadr_dp = '0;
  logic       mmwr_dp = 1'b0;
  logic       rfwr_dp = 1'b0;
  logic [2:0] alusel_dp = '0;
  logic [1:0] shiftsel_dp = '0;
  logic       outen_dp = 1'b0;
  logic       zero_dp;
  logic       positive_dp;
  logic [7:0] output_dp;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  datapath dut (
    .clk_dp(clk_dp), .rst_dp(rst_dp), .muxsel_dp(muxsel_dp), .imm_dp(imm_dp),
    .input_dp(input_dp), .accwr_dp(accwr_dp), .rfaddr_dp(rfaddr_dp),
    .mmadr_dp(mmadr_dp), .mmwr_dp(mmwr_dp), .rfwr_dp(rfwr_dp),
    .alusel_dp(alusel_dp), .shiftsel_dp(shiftsel_dp), .outen_dp(outen_dp),
    .zero_dp(zero_dp), .positive_dp(positive_dp), .output_dp(output_dp)
  );

  // Clock
  always #5 clk_dp = ~clk_dp;

  // Monitor: compare one expected tuple per falling edge
  always @(negedge clk_dp) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {output_dp, zero_dp, positive_dp};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: out=%02h zero=%b pos=%b, expected out=%02h zero=%b pos=%b",
                 nm, a[9:2], a[1], a[0], e[9:2], e[1], e[0]);
      end
    end
  end

  // Push an expectation; flags come from the ACC value the test intends
  task automatic chk(input string nm, input logic [7:0] out, input logic [7:0] acc);
    logic z;
    logic p;
    z = (acc == 8'h00);
    p = (acc != 8'h00) && !acc[7];
    exp_q.push_back({out, z, p});
    name_q.push_back(nm);
  endtask

  // Driver: apply one cycle of control, then drop all enables
  task automatic step(input logic [1:0] mux, input logic [2:0] alu, input logic [1:0] sh,
                      input logic [7:0] din, input logic [2:0] ra, input logic [3:0] ma,
                      input logic aw, input logic rw, input logic mw, input logic oe);
    @(negedge clk_dp);
    muxsel_dp = mux; alusel_dp = alu; shiftsel_dp = sh; input_dp = din;
    rfaddr_dp = ra; mmadr_dp = ma;
    accwr_dp = aw; rfwr_dp = rw; mmwr_dp = mw; outen_dp = oe;
    @(posedge clk_dp);
    #1;
    accwr_dp = 1'b0; rfwr_dp = 1'b0; mmwr_dp = 1'b0; outen_dp = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    step(2'b10, 3'b000, 2'b00, v, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu_op(input logic [2:0] alu, input logic [1:0] sh, input logic [2:0] ra);
    step(2'b00, alu, sh, 8'h00, ra, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Copy ACC to output_dp and expect that value there
  task automatic show(input string nm, input logic [7:0] acc);
    step(2'b00, 3'b000, 2'b00, 8'h00, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk(nm, acc, acc);
  endtask

  initial begin
    // Reset sequence
    repeat (2) @(posedge clk_dp);
    @(negedge clk_dp);
    chk("reset_initial", 8'h00, 8'h00);
    @(negedge clk_dp);
    rst_dp = 1'b0;

    // Fill RF and MEM with nonzero data so the reset clear is observable
    for (int i = 0; i < 8; i++) begin
      load(8'hA0 + 8'(i));
      step(2'b00, 3'b000, 2'b00, 8'h00, 3'(i), 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    for (int j = 0; j < 16; j++) begin
      load(8'h50 + 8'(j));
      step(2'b00, 3'b000, 2'b00, 8'h00, 3'd0, 4'(j), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    load(8'h77);
    show("prefill_out", 8'h77);
    step(2'b01, 3'b000, 2'b00, 8'h00, 3'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    show("prefill_rf6", 8'hA6);
    step(2'b11, 3'b000, 2'b00, 8'h00, 3'd0, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    show("prefill_mem13", 8'h5D);

    // Asynchronous reset between edges, with enables held high during it
    @(posedge clk_dp);
    #2;
    input_dp = 8'h33; muxsel_dp = 2'b10;
    accwr_dp = 1'b1; rfwr_dp = 1'b1; mmwr_dp = 1'b1; outen_dp = 1'b1;
    rst_dp = 1'b1;
    chk("reset_async", 8'h00, 8'h00);
    @(posedge clk_dp);
    chk("reset_overrides_enables", 8'h00, 8'h00);
    @(negedge clk_dp);
    accwr_dp = 1'b0; rfwr_dp = 1'b0; mmwr_dp = 1'b0; outen_dp = 1'b0;
    rst_dp = 1'b0;

    // Every register and memory word reads back as zero
    for (int i = 0; i < 8; i++) begin
      step(2'b01, 3'b000, 2'b00, 8'h00, 3'(i), 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      show($sformatf("rf_reset_%0d", i), 8'h00);
    end
    for (int j = 0; j < 16; j++) begin
      step(2'b11, 3'b000, 2'b00, 8'h00, 3'd0, 4'(j), 1'b1, 1'b0, 1'b0, 1'b0);
      show($sformatf("mem_reset_%0d", j), 8'h00);
    end

    // Load, store, output capture and hold
    load(8'h05);
    chk("load_flags_out_unchanged", 8'h00, 8'h05);
    step(2'b00, 3'b000, 2'b00, 8'h00, 3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    show("output_05", 8'h05);
    load(8'h09);
    chk("output_holds", 8'h05, 8'h09);
    load(8'h05);

    // ALU
    alu_op(3'b001, 2'b00, 3'd3);
    show("alu_add", 8'h0A);
    alu_op(3'b010, 2'b00, 3'd3);
    show("alu_sub", 8'h05);
    load(8'h0C);
    step(2'b00, 3'b000, 2'b00, 8'h00, 3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    load(8'h0A);
    alu_op(3'b011, 2'b00, 3'd3);
    show("alu_and", 8'h08);
    load(8'h0A);
    alu_op(3'b100, 2'b00, 3'd3);
    show("alu_or", 8'h0E);
    load(8'h0F);
    alu_op(3'b101, 2'b00, 3'd0);
    show("alu_not", 8'hF0);

    // Increment / decrement wrap-around
    load(8'hFF);
    alu_op(3'b110, 2'b00, 3'd0);
    show("inc_wrap", 8'h00);
    alu_op(3'b111, 2'b00, 3'd0);
    show("dec_wrap", 8'hFF);

    // Shifter
    load(8'h81);
    alu_op(3'b000, 2'b01, 3'd0);
    show("shift_left", 8'h02);
    load(8'h81);
    alu_op(3'b000, 2'b10, 3'd0);
    show("shift_right", 8'h40);
    load(8'h81);
    alu_op(3'b000, 2'b11, 3'd0);
    show("rotate_right", 8'hC0);

    // Memory store and simultaneous ACC load with register store
    load(8'h3C);
    step(2'b00, 3'b000, 2'b00, 8'h00, 3'd0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'h11);
    step(2'b11, 3'b000, 2'b00, 8'h00, 3'd0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    show("simul_acc_from_mem", 8'h3C);
    step(2'b01, 3'b000, 2'b00, 8'h00, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    show("simul_rf0_old_acc", 8'h11);
    step(2'b11, 3'b000, 2'b00, 8'h00, 3'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    show("mem9_readback", 8'h3C);
    step(2'b01, 3'b000, 2'b00, 8'h00, 3'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    show("rf3_kept", 8'h0C);

    // Output capture together with ACC load takes the old ACC
    step(2'b10, 3'b000, 2'b00, 8'h22, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("out_takes_old_acc", 8'h0C, 8'h22);

    // Let the monitor drain, bounded
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_dp);
    @(posedge clk_dp);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 8-bit accumulator-based datapath for the small 4-bit-PC microprocessor.
- Holds the accumulator (ACC), an 8x8 register file, a 16x8 data memory, an ALU and a shifter.
- Driven entirely by per-cycle control signals from the control unit; returns zero/positive status and a registered output port.
- Contains no sequencing logic of its own.

Parameters:
- WIDTH, 8, data width of ACC, register file, memory, ports.
- RF_DEPTH, 8, number of registers (addressed by rfaddr_dp).
- MEM_DEPTH, 16, number of data memory words (addressed by mmadr_dp).

Ports:
- clk_dp input 1: single clock; all state updates on the rising edge.
- rst_dp input 1: asynchronous, active-high reset.
- muxsel_dp input 2: ACC source select.
- imm_dp input 8: reserved immediate bus; ignored by this block.
- input_dp input 8: external/immediate data loaded into ACC.
- accwr_dp input 1: ACC write enable.
- rfaddr_dp input 3: register file address (read and write).
- mmadr_dp input 4: data memory address (read and write).
- mmwr_dp input 1: memory write enable.
- rfwr_dp input 1: register file write enable.
- alusel_dp input 3: ALU operation select.
- shiftsel_dp input 2: shifter operation select.
- outen_dp input 1: output register load enable.
- zero_dp output 1: ACC equals 0.
- positive_dp output 1: ACC is strictly positive (two's complement).
- output_dp output 8: registered output port.

Behaviour:
- Reset (async, rst_dp=1):
  - ACC, all registers, all memory words and output_dp clear to 0.
  - zero_dp=1 and positive_dp=0 follow from ACC=0.
  - Reset overrides every enable; reset asserted mid-operation discards any pending write.
- Reads (combinational):
  - R = RF[rfaddr_dp].
  - M = MEM[mmadr_dp].
- ALU (combinational, A=ACC, result mod 256, no carry/overflow outputs):
  - 000 pass A.
  - 001 A+R.
  - 010 A-R.
  - 011 A AND R.
  - 100 A OR R.
  - 101 NOT A.
  - 110 A+1.
  - 111 A-1.
- Shifter, applied to the ALU result:
  - 00 pass.
  - 01 shift left, LSB<=0.
  - 10 logical shift right, MSB<=0.
  - 11 rotate right, bit0 -> bit7.
- ACC input mux:
  - 00 shifter output.
  - 01 R.
  - 10 input_dp.
  - 11 M.
- Clock edge, when not in reset:
  - accwr_dp=1: ACC <= mux output.
  - rfwr_dp=1: RF[rfaddr_dp] <= ACC (pre-edge value).
  - mmwr_dp=1: MEM[mmadr_dp] <= ACC (pre-edge value).
  - outen_dp=1: output_dp <= ACC (pre-edge value); otherwise output_dp holds.
- Simultaneous enables are all honoured in the same cycle. Every store and output capture takes the old ACC; ACC takes the new value. Example: accwr+rfwr with muxsel=01 at the same address gives an ACC/register swap-safe read-before-write.
- Flags are combinational from the current ACC:
  - zero_dp = (ACC==0).
  - positive_dp = (ACC[7]==0) && (ACC!=0).
- Wrap-around:
  - 0xFF+1 -> 0x00 with zero_dp=1.
  - 0x00-1 -> 0xFF with positive_dp=0.
- Latency:
  - ACC, RF, MEM and output_dp update one edge after enables are sampled high.
  - Flags are valid in the same cycle as the new ACC.
- No enables asserted: all state holds.

Test Plan:
- Reset: assert rst_dp asynchronously between edges -> immediately ACC=0, output_dp=0, zero_dp=1, positive_dp=0; RF[0..7]=0, MEM[0..15]=0.
- Load/store/output:
  - input_dp=0x05, muxsel=10, accwr=1 -> ACC=0x05, zero=0, positive=1.
  - Then rfwr=1, rfaddr=3 -> RF[3]=0x05.
  - Then outen=1 -> output_dp=0x05 and holds after outen drops.
- ALU:
  - With ACC=0x05 and RF[3]=0x05: alusel=001, accwr -> ACC=0x0A.
  - alusel=010 -> 0x05; alusel=011 with RF[3]=0x0C and ACC=0x0A -> 0x08; alusel=100 -> 0x0E.
  - alusel=101 on ACC=0x0F -> 0xF0, positive=0, zero=0.
- Inc/dec wrap: ACC=0xFF, alusel=110 -> 0x00, zero=1; then alusel=111 -> 0xFF.
- Shifter on ACC=0x81:
  - shiftsel=01 -> 0x02.
  - Reload 0x81, shiftsel=10 -> 0x40.
  - Reload 0x81, shiftsel=11 -> 0xC0.
- Memory and simultaneous writes:
  - ACC=0x3C, mmwr=1, mmadr=9 -> MEM[9]=0x3C.
  - Load ACC=0x11, then muxsel=11, mmadr=9, accwr=1, rfwr=1, rfaddr=0 in one cycle -> ACC=0x3C, RF[0]=0x11.
